vga_mem_arbiter: RTL
====================

VGA_MEM_ARBITER -- requirements
Module: vga_mem_arbiter

Interface
REQ-001 SHALL have parameter H_PIX, default 360, meaning framebuffer pixels per line.
REQ-002 SHALL have parameter V_LINES, default 225, meaning framebuffer lines.
REQ-003 SHALL have parameter MEM_LAT, default 1, meaning memory read latency in cycles (1..3).
REQ-004 SHALL have port clk, input, 1 bit: pixel clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port line_start, input, 1 bit: single-cycle pulse from the timing generator requesting a line fetch.
REQ-007 SHALL have port line_y, input, 8 bits: framebuffer line to fetch, sampled with line_start.
REQ-008 SHALL have ports wr_req, input, 1 bit; wr_addr, input, 17 bits; wr_data, input, 12 bits: drawing-side write request.
REQ-009 SHALL have port wr_ack, output, 1 bit: write accepted this cycle.
REQ-010 SHALL have ports mem_en, mem_we, output, 1 bit each; mem_addr, output, 17 bits; mem_wdata, output, 12 bits; mem_rdata, input, 12 bits: single-port framebuffer RAM.
REQ-011 SHALL have ports lb_we, output, 1 bit; lb_addr, output, 9 bits; lb_data, output, 12 bits: line-buffer write port.
REQ-012 SHALL have ports fetch_done, output, 1 bit (pulse) and err, output, 1 bit (sticky).

Function
REQ-013 SHALL implement states IDLE, FETCH, DRAIN.
REQ-014 In IDLE, line_start with line_y < V_LINES SHALL latch base = line_y*H_PIX, computed with shift-add, 17 bits and no truncation, then enter FETCH next cycle.
REQ-015 In FETCH, the block SHALL issue one read per cycle (mem_en=1, mem_we=0, mem_addr=base+i) for i=0..H_PIX-1, then enter DRAIN.
REQ-016 Read data SHALL be written to the line buffer exactly MEM_LAT cycles after issue, with lb_addr=i and lb_data=mem_rdata.
REQ-017 DRAIN SHALL last MEM_LAT cycles; fetch_done SHALL pulse for one cycle with the last lb_we, then the FSM returns to IDLE.
REQ-018 Fetch SHALL have strict priority: wr_ack SHALL be 0 in FETCH and DRAIN, and in any IDLE cycle where line_start is 1.
REQ-019 In IDLE with wr_req=1 and no line_start, wr_ack SHALL be 1 combinationally, with mem_en=1, mem_we=1, mem_addr=wr_addr and mem_wdata=wr_data in the same cycle.
REQ-020 A write with wr_addr >= H_PIX*V_LINES SHALL be acked but not driven to memory (mem_en=0), and SHALL set err.
REQ-021 line_start in FETCH or DRAIN SHALL be ignored and SHALL set err; the current fetch SHALL continue.
REQ-022 line_start with line_y >= V_LINES SHALL be ignored and SHALL set err.
REQ-023 err SHALL clear only on reset.

Reset
REQ-024 While rst_n=0, the state SHALL be IDLE and all outputs 0 (wr_ack, mem_*, lb_*, fetch_done, err, counters).
REQ-025 Reset asserted mid-fetch SHALL abort the fetch immediately with no further lb_we; the first line_start after release SHALL start a fresh fetch.

Configuration
REQ-026 With VGA_ARB_STATS_EN defined, the block SHALL add output stall_cnt, 16 bits, counting cycles with wr_req=1 and wr_ack=0, saturating at 0xFFFF and reset to 0.
REQ-027 Without VGA_ARB_STATS_EN, the stall_cnt port and its logic SHALL be absent and behaviour SHALL otherwise be identical.

Structure
REQ-028 Package vga_pkg SHALL hold the H_PIX and V_LINES defaults, FB_AW=17, LB_AW=9, PIX_W=12, and the FSM state enum.
REQ-029 Sub-module vga_fetch_addr SHALL contain the base multiply and the i counter, and SHALL output mem_addr, lb_addr and the last-read flag.

Verification
REQ-030 line_y=0 line_start, MEM_LAT=1: reads at addr 0..359 on consecutive cycles; lb_we with lb_addr 0..359 one cycle later; fetch_done with lb_addr=359.
REQ-031 line_y=224: first mem_addr=80640, last=80999; no err.
REQ-032 wr_req held high across line_start: wr_ack=0 from the line_start cycle through DRAIN, then wr_ack=1 in the first IDLE cycle.
REQ-033 Second line_start mid-FETCH, line_y=225, and a write to wr_addr=81000 (each case run separately): err=1, running fetch unaffected, no memory access for the bad write.
REQ-034 rst_n low at i=100: all outputs 0 next edge, no lb_we after; new fetch after release starts at i=0.
REQ-035 With VGA_ARB_STATS_EN defined, wr_req held high through one full fetch at MEM_LAT=1: stall_cnt=362 (1 line_start cycle + 360 FETCH + 1 DRAIN).

Source files
------------

// File: rtl/vga_mem_arbiter_pkg.sv
// Shared definitions for the VGA framebuffer arbiter: default geometry,
// bus widths, FSM state type and the constant-coefficient line-base multiply.
package vga_pkg;

  localparam int H_PIX_DEF   = 360;
  localparam int V_LINES_DEF = 225;
  localparam int FB_AW       = 17;
  localparam int LB_AW       = 9;
  localparam int PIX_W       = 12;
  localparam int LY_W        = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } arb_state_t;

  // y * hpix built as a sum of shifted copies of y, one per set bit of the
  // constant hpix; the full product fits FB_AW bits for any legal y.
  function automatic logic [FB_AW-1:0] line_base(input logic [LY_W-1:0] y,
                                                 input int unsigned hpix);
    logic [FB_AW-1:0] acc;
    logic [FB_AW-1:0] ext;
    acc = '0;
    ext = {{(FB_AW-LY_W){1'b0}}, y};
    for (int k = 0; k < FB_AW; k++) begin
      if (hpix[k]) acc = acc + (ext << k);
    end
    return acc;
  endfunction

endpackage

// File: rtl/vga_mem_arbiter_if.sv
// Bus bundle between the arbiter and its environment: timing generator
// request, drawing-side write port, framebuffer RAM and line-buffer port.
// With VGA_ARB_STATS_EN defined the bundle also carries stall_cnt.
interface vga_mem_arbiter_if;
  import vga_pkg::*;

  logic                 line_start;
  logic [LY_W-1:0]      line_y;
  logic                 wr_req;
  logic [FB_AW-1:0]     wr_addr;
  logic [PIX_W-1:0]     wr_data;
  logic                 wr_ack;
  logic                 mem_en;
  logic                 mem_we;
  logic [FB_AW-1:0]     mem_addr;
  logic [PIX_W-1:0]     mem_wdata;
  logic [PIX_W-1:0]     mem_rdata;
  logic                 lb_we;
  logic [LB_AW-1:0]     lb_addr;
  logic [PIX_W-1:0]     lb_data;
  logic                 fetch_done;
  logic                 err;
`ifdef VGA_ARB_STATS_EN
  logic [15:0]          stall_cnt;
`endif

  // Arbiter side
  modport master (
    input  line_start, line_y, wr_req, wr_addr, wr_data, mem_rdata,
    output wr_ack, mem_en, mem_we, mem_addr, mem_wdata,
           lb_we, lb_addr, lb_data, fetch_done, err
`ifdef VGA_ARB_STATS_EN
    , output stall_cnt
`endif
  );

  // Environment side
  modport slave (
    output line_start, line_y, wr_req, wr_addr, wr_data, mem_rdata,
    input  wr_ack, mem_en, mem_we, mem_addr, mem_wdata,
           lb_we, lb_addr, lb_data, fetch_done, err
`ifdef VGA_ARB_STATS_EN
    , input stall_cnt
`endif
  );

endinterface

// File: rtl/vga_fetch_addr.sv
// Line-fetch address generator: latches the line base, walks the pixel
// index, and delays the index by the RAM latency so the line-buffer write
// lines up with the returning read data.
module vga_fetch_addr
  import vga_pkg::*;
#(
  parameter int H_PIX   = H_PIX_DEF,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [LY_W-1:0]   line_y,
  input  logic              advance,
  output logic [FB_AW-1:0]  mem_addr,
  output logic              rd_last,
  output logic              lb_vld,
  output logic [LB_AW-1:0]  lb_addr,
  output logic              lb_last
);

  logic [FB_AW-1:0]   base_p0;
  logic [LB_AW-1:0]   idx_p0;
  logic [MEM_LAT-1:0] vld_p1;
  logic [MEM_LAT-1:0] last_p1;
  logic [LB_AW-1:0]   idx_p1 [MEM_LAT];

  // Latch the line base address when a fetch is accepted
  always_ff @(posedge clk) begin
    if (load) base_p0 <= line_base(line_y, H_PIX);
  end

  // Pixel index within the line, restarted on every accepted fetch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) idx_p0 <= '0;
    else if (load) idx_p0 <= '0;
    else if (advance) idx_p0 <= idx_p0 + 1'b1;
  end

  assign mem_addr = base_p0 + {{(FB_AW-LB_AW){1'b0}}, idx_p0};
  assign rd_last  = (idx_p0 == LB_AW'(H_PIX - 1));

  // ---- read issue -> read data return (MEM_LAT cycles) ----
  // Control side of the latency pipe; cleared on reset so an aborted fetch
  // produces no further line-buffer writes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= '0;
      last_p1 <= '0;
    end else begin
      vld_p1[0]  <= advance;
      last_p1[0] <= advance & rd_last;
      for (int k = 1; k < MEM_LAT; k++) begin
        vld_p1[k]  <= vld_p1[k-1];
        last_p1[k] <= last_p1[k-1];
      end
    end
  end

  // Data side of the latency pipe: the line-buffer index
  always_ff @(posedge clk) begin
    idx_p1[0] <= idx_p0;
    for (int k = 1; k < MEM_LAT; k++) idx_p1[k] <= idx_p1[k-1];
  end

  assign lb_vld  = vld_p1[MEM_LAT-1];
  assign lb_addr = idx_p1[MEM_LAT-1];
  assign lb_last = last_p1[MEM_LAT-1];

endmodule

// File: rtl/vga_mem_arbiter.sv
// Single-port framebuffer arbiter. Line fetches for the display have strict
// priority over drawing-side writes; writes are acked combinationally when
// the arbiter is idle. Optional feature macro: VGA_ARB_STATS_EN adds a
// saturating stall counter (stall_cnt) on the bus interface.
module vga_mem_arbiter
  import vga_pkg::*;
#(
  parameter int H_PIX   = H_PIX_DEF,
  parameter int V_LINES = V_LINES_DEF,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  vga_mem_arbiter_if.master bus
);

  localparam logic [FB_AW-1:0] FB_WORDS = FB_AW'(H_PIX * V_LINES);
  localparam logic [LY_W:0]    V_LIM    = (LY_W+1)'(V_LINES);

  arb_state_t        state, state_nxt;
  logic              load, advance, wr_ack_c, err_set;
  logic              y_ok, wr_ok, wr_go;
  logic              err_q;
  logic [FB_AW-1:0]  fetch_addr;
  logic              rd_last, lb_vld, lb_last;
  logic [LB_AW-1:0]  lb_idx;

  assign y_ok  = ({1'b0, bus.line_y} < V_LIM);
  assign wr_ok = (bus.wr_addr < FB_WORDS);

  vga_fetch_addr #(
    .H_PIX   (H_PIX),
    .MEM_LAT (MEM_LAT)
  ) u_fetch_addr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .line_y   (bus.line_y),
    .advance  (advance),
    .mem_addr (fetch_addr),
    .rd_last  (rd_last),
    .lb_vld   (lb_vld),
    .lb_addr  (lb_idx),
    .lb_last  (lb_last)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  end

  // Next state, fetch control, write grant and error detection
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    advance   = 1'b0;
    wr_ack_c  = 1'b0;
    err_set   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.line_start) begin
          if (y_ok) begin
            load      = 1'b1;
            state_nxt = FETCH;
          end else begin
            err_set = 1'b1;
          end
        end else if (bus.wr_req) begin
          wr_ack_c = 1'b1;
          err_set  = ~wr_ok;
        end
      end
      FETCH: begin
        advance = 1'b1;
        err_set = bus.line_start;
        if (rd_last) state_nxt = DRAIN;
      end
      DRAIN: begin
        err_set = bus.line_start;
        if (lb_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Sticky error flag, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else if (err_set) err_q <= 1'b1;
  end

  // The ack is forced low during reset because IDLE is the reset state
  assign wr_go          = wr_ack_c & wr_ok & rst_n;
  assign bus.wr_ack     = wr_ack_c & rst_n;
  assign bus.mem_en     = advance | wr_go;
  assign bus.mem_we     = wr_go;
  assign bus.mem_addr   = advance ? fetch_addr : (wr_go ? bus.wr_addr : '0);
  assign bus.mem_wdata  = wr_go ? bus.wr_data : '0;
  assign bus.lb_we      = lb_vld;
  assign bus.lb_addr    = lb_vld ? lb_idx : '0;
  assign bus.lb_data    = lb_vld ? bus.mem_rdata : '0;
  assign bus.fetch_done = lb_last;
  assign bus.err        = err_q;

`ifdef VGA_ARB_STATS_EN
  logic [15:0] stall_q;

  // Count cycles where the drawing side is held off, saturating at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_q <= '0;
    else if (bus.wr_req && !wr_ack_c && (stall_q != 16'hFFFF)) stall_q <= stall_q + 16'd1;
  end

  assign bus.stall_cnt = stall_q;
`endif

endmodule
